pll_reset_seq: RTL and testbench

PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

---
 rtl/pll_reset_seq.sv | 124 ++++++++++++
 tb/tb_pll_reset_seq.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_seq.sv
// PLL reset sequencer: pulses the PLL reset and waits for a stable lock before releasing
// the system reset. It retries when a lock attempt times out and latches FAIL once the retries run out.
module pll_reset_seq #(
    parameter int RST_PULSE_CYC    = 64,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int LOCK_TIMEOUT_CYC = 1048576,
    parameter int MAX_RETRIES      = 3
) (
    input  logic       clk_74a,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       sys_reset_n,
    output logic       pll_ok,
    output logic       fail,
    output logic [3:0] retry_count,
    output logic [7:0] lock_loss_count
);

    localparam int MAX_AB  = (RST_PULSE_CYC > LOCK_STABLE_CYC) ? RST_PULSE_CYC : LOCK_STABLE_CYC;
    localparam int CNT_MAX = (MAX_AB > LOCK_TIMEOUT_CYC) ? MAX_AB : LOCK_TIMEOUT_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABILIZE,
        RUN,
        FAIL
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             sync_meta;
    logic             locked_s;
    logic [3:0]       retry_next;
    logic [7:0]       loss_next;

    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= 1'b0;
            locked_s  <= 1'b0;
        end else begin
            sync_meta <= pll_locked;
            locked_s  <= sync_meta;
        end
    end

    always_comb begin
        state_next = state;
        retry_next = retry_count;
        loss_next  = lock_loss_count;
        case (state)
            RESET_PLL: begin
                if (cnt == CNT_W'(RST_PULSE_CYC - 1)) state_next = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_next = STABILIZE;
                end else if (cnt == CNT_W'(LOCK_TIMEOUT_CYC - 1)) begin
                    if (int'(retry_count) < MAX_RETRIES) begin
                        state_next = RESET_PLL;
                        if (retry_count != 4'hF) retry_next = retry_count + 4'd1;
                    end else begin
                        state_next = FAIL;
                    end
                end
            end
            STABILIZE: begin
                // Any dropout restarts the wait with a fresh timeout but costs no retry
                if (!locked_s) begin
                    state_next = WAIT_LOCK;
                end else if (cnt == CNT_W'(LOCK_STABLE_CYC - 1)) begin
                    state_next = RUN;
                    retry_next = 4'd0;
                end
            end
            RUN: begin
                if (!locked_s || relock_req) begin
                    state_next = RESET_PLL;
                    retry_next = 4'd0;
                    if (!locked_s && lock_loss_count != 8'hFF) loss_next = lock_loss_count + 8'd1;
                end
            end
            FAIL: begin
                if (relock_req) begin
                    state_next = RESET_PLL;
                    retry_next = 4'd0;
                end
            end
            default: state_next = RESET_PLL;
        endcase
    end

    // Outputs decode the next state so they line up exactly with the registered state
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            state           <= RESET_PLL;
            cnt             <= '0;
            pll_rst         <= 1'b1;
            sys_reset_n     <= 1'b0;
            pll_ok          <= 1'b0;
            fail            <= 1'b0;
            retry_count     <= 4'd0;
            lock_loss_count <= 8'd0;
        end else begin
            state           <= state_next;
            retry_count     <= retry_next;
            lock_loss_count <= loss_next;
            if (state_next != state) begin
                cnt <= '0;
            end else if (cnt != CNT_W'(CNT_MAX)) begin
                cnt <= cnt + 1'b1;
            end
            pll_rst     <= (state_next == RESET_PLL) || (state_next == FAIL);
            sys_reset_n <= (state_next == RUN);
            pll_ok      <= (state_next == RUN);
            fail        <= (state_next == FAIL);
        end
    end

endmodule

// File: tb/tb_pll_reset_seq.sv
// Randomized bench for pll_reset_seq: lock-event traces are predicted by a phase-level model,
// and a monitor matches each observed output change against the queued expectations.
module tb_pll_reset_seq;

    localparam int RST   = 4;
    localparam int STB   = 8;
    localparam int TO    = 32;
    localparam int MAXR  = 2;
    localparam int DEPTH = 1024;
    localparam logic [15:0] RESET_VEC = 16'h8000;

    typedef struct {
        int          edge_no;
        logic [15:0] vec;
    } exp_t;

    logic       clk_74a = 1'b0;
    logic       reset_n;
    logic       pll_locked;
    logic       relock_req;
    logic       pll_rst;
    logic       sys_reset_n;
    logic       pll_ok;
    logic       fail;
    logic [3:0] retry_count;
    logic [7:0] lock_loss_count;
    logic [15:0] dut_vec;

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          base     = 0;
    int          n_edges  = 0;
    logic        lk[DEPTH];
    logic        rq[DEPTH];
    logic [15:0] last_vec;
    logic [15:0] prev_vec;
    logic        in_reset;

    pll_reset_seq #(
        .RST_PULSE_CYC(RST),
        .LOCK_STABLE_CYC(STB),
        .LOCK_TIMEOUT_CYC(TO),
        .MAX_RETRIES(MAXR)
    ) dut (
        .clk_74a(clk_74a),
        .reset_n(reset_n),
        .pll_locked(pll_locked),
        .relock_req(relock_req),
        .pll_rst(pll_rst),
        .sys_reset_n(sys_reset_n),
        .pll_ok(pll_ok),
        .fail(fail),
        .retry_count(retry_count),
        .lock_loss_count(lock_loss_count)
    );

    always #5 clk_74a = ~clk_74a;
    always @(posedge clk_74a) cyc <= cyc + 1;
    assign dut_vec = {pll_rst, sys_reset_n, pll_ok, fail, retry_count, lock_loss_count};

    // Lock as seen by the sequencer's decision at edge n: two edges of synchronizer delay
    function automatic logic sync_at(int n);
        if (n < 3 || n - 2 >= DEPTH) return 1'b0;
        return lk[n - 2];
    endfunction

    function automatic logic rq_at(int n);
        if (n < 1 || n >= DEPTH) return 1'b0;
        return rq[n];
    endfunction

    function automatic void emit(int e, logic r, logic s, logic o, logic f, int retry, int loss);
        logic [15:0] v;
        v = {r, s, o, f, 4'(retry), 8'(loss)};
        if (e > n_edges) return;
        if (v != last_vec) begin
            exp_q.push_back('{edge_no: e, vec: v});
            last_vec = v;
        end
    endfunction

    // Walks whole phases at once: each phase finds its exit edge by searching the trace
    function automatic void predict();
        string phase;
        int    e, retry, loss, k;
        logic  hit;
        phase    = "reset";
        e        = 0;
        retry    = 0;
        loss     = 0;
        last_vec = RESET_VEC;
        while (e <= n_edges) begin
            if (phase == "reset") begin
                e += RST;
                emit(e, 1'b0, 1'b0, 1'b0, 1'b0, retry, loss);
                phase = "wait";
            end else if (phase == "wait") begin
                hit = 1'b0;
                for (k = 1; k <= TO; k++) if (sync_at(e + k)) begin hit = 1'b1; break; end
                if (hit) begin
                    e += k;
                    phase = "stab";
                end else begin
                    e += TO;
                    if (retry < MAXR) begin
                        retry++;
                        phase = "reset";
                        emit(e, 1'b1, 1'b0, 1'b0, 1'b0, retry, loss);
                    end else begin
                        phase = "fail";
                        emit(e, 1'b1, 1'b0, 1'b0, 1'b1, retry, loss);
                    end
                end
            end else if (phase == "stab") begin
                hit = 1'b0;
                for (k = 1; k <= STB; k++) if (!sync_at(e + k)) begin hit = 1'b1; break; end
                if (hit) begin
                    e += k;
                    phase = "wait";
                end else begin
                    e += STB;
                    retry = 0;
                    phase = "run";
                    emit(e, 1'b0, 1'b1, 1'b1, 1'b0, retry, loss);
                end
            end else if (phase == "run") begin
                k = 1;
                while (e + k <= n_edges && sync_at(e + k) && !rq_at(e + k)) k++;
                e += k;
                if (e <= n_edges) begin
                    if (!sync_at(e) && loss < 255) loss++;
                    retry = 0;
                    phase = "reset";
                    emit(e, 1'b1, 1'b0, 1'b0, 1'b0, retry, loss);
                end
            end else begin
                k = 1;
                while (e + k <= n_edges && !rq_at(e + k)) k++;
                e += k;
                if (e <= n_edges) begin
                    retry = 0;
                    phase = "reset";
                    emit(e, 1'b1, 1'b0, 1'b0, 1'b0, retry, loss);
                end
            end
        end
    endfunction

    task automatic check_output(string name, logic [15:0] act, logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor: the only process that counts comparisons
    initial begin
        in_reset = 1'b0;
        prev_vec = RESET_VEC;
        #2;
        forever begin
            @(negedge clk_74a or negedge reset_n);
            if (!reset_n) begin
                if (!in_reset) begin
                    in_reset = 1'b1;
                    checks++;
                    if (exp_q.size() != 0) begin
                        failures++;
                        $display("[TB] FAIL pending_events: got %0d outstanding, required 0 (next edge %0d vec %h)",
                                 exp_q.size(), exp_q[0].edge_no, exp_q[0].vec);
                        exp_q.delete();
                    end
                    #1;
                    check_output("async_reset", dut_vec, RESET_VEC);
                end
                prev_vec = dut_vec;
            end else begin
                in_reset = 1'b0;
                if (dut_vec !== prev_vec) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("[TB] FAIL unexpected_change: got %h at edge %0d, required no change",
                                 dut_vec, cyc - base);
                    end else begin
                        exp_t x;
                        x = exp_q.pop_front();
                        if (x.edge_no != cyc - base || x.vec !== dut_vec) begin
                            failures++;
                            $display("[TB] FAIL output_event: got %h at edge %0d, required %h at edge %0d",
                                     dut_vec, cyc - base, x.vec, x.edge_no);
                        end
                    end
                end
                prev_vec = dut_vec;
            end
        end
    end

    function automatic int stab_entry(int d);
        return (d + 2 > RST) ? d + 2 : RST + 1;
    endfunction

    function automatic void lock_from(int d);
        for (int n = d; n < DEPTH; n++) lk[n] = 1'b1;
    endfunction

    task automatic build(int kind, bit directed);
        int d, s, g, m, len, v, n, run;
        for (int i = 0; i < DEPTH; i++) begin
            lk[i] = 1'b0;
            rq[i] = 1'b0;
        end
        case (kind)
            0: begin
                d = directed ? 10 : int'($urandom_range(1, 20));
                lock_from(d);
                n_edges = stab_entry(d) + STB + int'($urandom_range(5, 20));
            end
            1: begin
                d = int'($urandom_range(1, 10));
                lock_from(d);
                s = stab_entry(d);
                g = directed ? 5 : int'($urandom_range(1, STB - 1));
                lk[s + g - 2] = 1'b0;
                n_edges = s + 60;
            end
            2: begin
                m = int'($urandom_range(110, 170));
                rq[m] = 1'b1;
                lock_from(m + int'($urandom_range(1, 10)));
                n_edges = m + 60;
            end
            3, 4: begin
                d = int'($urandom_range(1, 10));
                lock_from(d);
                s = stab_entry(d) + STB;
                m = s + int'($urandom_range(1, 10));
                if (kind == 4 && !directed && $urandom_range(0, 1) == 1) begin
                    rq[m] = 1'b1;
                end else begin
                    len = (kind == 4) ? int'($urandom_range(1, 3)) : int'($urandom_range(1, 6));
                    for (int i = 0; i < len; i++) lk[m + i] = 1'b0;
                    if (kind == 4) rq[m + 2] = 1'b1;
                end
                n_edges = m + 70;
            end
            5: begin
                n_edges = int'($urandom_range(150, 300));
                v = int'($urandom_range(0, 1));
                n = 1;
                while (n < DEPTH) begin
                    run = int'($urandom_range(1, 24));
                    for (int i = 0; i < run && n < DEPTH; i++) begin
                        lk[n] = v[0];
                        n++;
                    end
                    v = 1 - v;
                end
                for (int i = 1; i <= n_edges; i++) rq[i] = ($urandom_range(0, 39) == 0);
            end
            default: begin
                d = int'($urandom_range(1, 10));
                lock_from(d);
                n_edges = stab_entry(d) + int'($urandom_range(1, STB - 1));
            end
        endcase
    endtask

    task automatic apply_stimulus(int kind, bit directed);
        build(kind, directed);
        predict();
        @(negedge clk_74a);
        #2;
        pll_locked = lk[1];
        relock_req = rq[1];
        base       = cyc;
        reset_n    = 1'b1;
        for (int n = 2; n <= n_edges; n++) begin
            @(negedge clk_74a);
            pll_locked = lk[n];
            relock_req = rq[n];
        end
        @(negedge clk_74a);
        #2;
        reset_n    = 1'b0;
        pll_locked = 1'b0;
        relock_req = 1'b0;
        repeat (2) @(negedge clk_74a);
    endtask

    initial begin
        reset_n    = 1'b0;
        pll_locked = 1'b0;
        relock_req = 1'b0;
        repeat (3) @(negedge clk_74a);
        apply_stimulus(0, 1'b1);
        apply_stimulus(1, 1'b1);
        apply_stimulus(2, 1'b1);
        apply_stimulus(3, 1'b1);
        apply_stimulus(4, 1'b1);
        apply_stimulus(6, 1'b1);
        for (int t = 0; t < 24; t++) apply_stimulus(int'($urandom_range(0, 6)), 1'b0);
        repeat (3) @(negedge clk_74a);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
